link_peer: RTL and testbench

- Far end of the Game Boy serial link port. It is the cable partner that the Serial block talks to when the Game Boy drives the internal clock.
- Samples the Game Boy's SCK and SOUT pins, shifts a response byte back on SIN, and delivers each received byte to a host/bench byte interface.
- Sits outside the Gameboy top and connects pin-to-pin with the Serial block's link signals.

---
 rtl/link_pkg.sv | 13 +
 rtl/link_fifo.sv | 70 +++++++
 rtl/link_peer.sv | 240 ++++++++++++++++++++++++
 tb/tb_link_peer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared types and constants for the link_peer serial cable partner.
package link_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } link_state_t;

    localparam logic [7:0] LINK_IDLE_BYTE = 8'hFF;

    typedef logic [2:0] link_bit_cnt_t;

endpackage

// File: rtl/link_fifo.sv
// Response byte queue: synchronous FIFO with async active-high reset and registered flags.
module link_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] CNT_FULL = FIFO_DEPTH[AW:0];

    logic [WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             push_s;
    logic             pop_s;

    assign push_s = push & ~full_r;
    assign pop_s  = pop & ~empty_r;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + 1'b1;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - 1'b1;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointers, occupancy and flags; pointers wrap naturally since depth is a power of 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_FULL);
            empty_r <= (count_nxt_s == {(AW+1){1'b0}});
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= din;
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/link_peer.sv
// Game Boy link cable partner: answers SCK/SOUT with queued bytes on SIN.
// Optional peer-driven clock: define LINK_PEER_CLK_MASTER_EN.
module link_peer
    import link_pkg::*;
#(
    parameter int          FIFO_DEPTH      = 4,
    parameter logic [7:0]  IDLE_BYTE       = LINK_IDLE_BYTE,
    parameter int          TIMEOUT_CYCLES  = 16384,
    parameter int          SCK_HALF_PERIOD = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck_in,
    input  logic       sd_in,
`ifdef LINK_PEER_CLK_MASTER_EN
    input  logic       start,
`endif
    output logic       sd_out,
    output logic       sck_out,
    output logic       sck_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       timeout_err
);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("link_peer: FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if ((TIMEOUT_CYCLES < 2) || (SCK_HALF_PERIOD < 1)) begin : g_bad_timing
        $error("link_peer: TIMEOUT_CYCLES must be >= 2 and SCK_HALF_PERIOD >= 1");
    end

    localparam int TW         = $clog2(TIMEOUT_CYCLES);
    localparam int IDLE_MAX_I = TIMEOUT_CYCLES - 1;
    localparam logic [TW-1:0] IDLE_MAX = IDLE_MAX_I[TW-1:0];
`ifdef LINK_PEER_CLK_MASTER_EN
    localparam logic TIMEOUT_EN = 1'b0;
`else
    localparam logic TIMEOUT_EN = 1'b1;
`endif

    link_state_t   state_r, state_nxt_s;
    logic [7:0]    tx_shift_r, tx_shift_nxt_s;
    logic [6:0]    rx_shift_r, rx_shift_nxt_s;
    link_bit_cnt_t bit_cnt_r, bit_cnt_nxt_s;
    logic [TW-1:0] idle_cnt_r, idle_cnt_nxt_s;
    logic          sd_out_r, sd_out_nxt_s;
    logic [7:0]    rx_data_r, rx_data_nxt_s;
    logic          rx_valid_r, rx_valid_nxt_s;
    logic          busy_r, busy_nxt_s;
    logic          timeout_r, timeout_nxt_s;
    logic          sck_meta_r, sck_sync_r, sck_prev_r;
    logic          sd_meta_r, sd_sync_r;
    logic          rise_s, fall_s;
    logic          pop_s, fifo_full_s, fifo_empty_s;
    logic [7:0]    fifo_head_s, load_s;
    logic          timeout_hit_s;

    link_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_valid),
        .pop   (pop_s),
        .din   (tx_data),
        .head  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Pin synchronisers; idle-high reset values keep reset release edge-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_meta_r <= 1'b1;
            sck_sync_r <= 1'b1;
            sck_prev_r <= 1'b1;
            sd_meta_r  <= 1'b1;
            sd_sync_r  <= 1'b1;
        end else begin
            sck_meta_r <= sck_in;
            sck_sync_r <= sck_meta_r;
            sck_prev_r <= sck_sync_r;
            sd_meta_r  <= sd_in;
            sd_sync_r  <= sd_meta_r;
        end
    end

`ifdef LINK_PEER_CLK_MASTER_EN
    localparam int HW         = (SCK_HALF_PERIOD > 1) ? $clog2(SCK_HALF_PERIOD) : 1;
    localparam int HALF_MAX_I = SCK_HALF_PERIOD - 1;
    localparam logic [HW-1:0] HALF_MAX = HALF_MAX_I[HW-1:0];

    logic          m_active_r, sck_out_r, sck_oe_r;
    logic [HW-1:0] half_cnt_r;
    logic [3:0]    edge_cnt_r;
    logic          launch_s, toggle_s;

    assign launch_s = start & ~m_active_r & (state_r == IDLE);
    assign toggle_s = m_active_r & (half_cnt_r == HALF_MAX);
    assign fall_s   = launch_s | (toggle_s & sck_out_r);
    assign rise_s   = toggle_s & ~sck_out_r;

    // Peer clock generator: the launch edge is the first fall, the 16th edge is the last rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active_r <= 1'b0;
            sck_out_r  <= 1'b1;
            sck_oe_r   <= 1'b0;
            half_cnt_r <= {HW{1'b0}};
            edge_cnt_r <= 4'd0;
        end else if (launch_s) begin
            m_active_r <= 1'b1;
            sck_out_r  <= 1'b0;
            sck_oe_r   <= 1'b1;
            half_cnt_r <= {HW{1'b0}};
            edge_cnt_r <= 4'd1;
        end else if (toggle_s) begin
            sck_out_r  <= ~sck_out_r;
            half_cnt_r <= {HW{1'b0}};
            edge_cnt_r <= edge_cnt_r + 4'd1;
            if (edge_cnt_r == 4'd15) begin
                m_active_r <= 1'b0;
                sck_oe_r   <= 1'b0;
            end
        end else if (m_active_r) begin
            half_cnt_r <= half_cnt_r + 1'b1;
        end
    end

    assign sck_out = sck_out_r;
    assign sck_oe  = sck_oe_r;
`else
    assign rise_s  = sck_sync_r & ~sck_prev_r;
    assign fall_s  = ~sck_sync_r & sck_prev_r;
    assign sck_out = 1'b1;
    assign sck_oe  = 1'b0;
`endif

    assign timeout_hit_s = TIMEOUT_EN & (idle_cnt_r == IDLE_MAX);
    assign load_s        = fifo_empty_s ? IDLE_BYTE : fifo_head_s;

    // Byte transfer next-state and output logic.
    always_comb begin
        state_nxt_s    = state_r;
        tx_shift_nxt_s = tx_shift_r;
        rx_shift_nxt_s = rx_shift_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        idle_cnt_nxt_s = idle_cnt_r;
        sd_out_nxt_s   = sd_out_r;
        rx_data_nxt_s  = rx_data_r;
        rx_valid_nxt_s = 1'b0;
        busy_nxt_s     = busy_r;
        timeout_nxt_s  = 1'b0;
        pop_s          = 1'b0;
        case (state_r)
            IDLE: begin
                if (fall_s) begin
                    pop_s          = ~fifo_empty_s;
                    sd_out_nxt_s   = load_s[7];
                    tx_shift_nxt_s = {load_s[6:0], 1'b0};
                    bit_cnt_nxt_s  = 3'd0;
                    idle_cnt_nxt_s = {TW{1'b0}};
                    busy_nxt_s     = 1'b1;
                    state_nxt_s    = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (rise_s) begin
                    rx_shift_nxt_s = {rx_shift_r[5:0], sd_sync_r};
                    bit_cnt_nxt_s  = bit_cnt_r + 3'd1;
                    idle_cnt_nxt_s = {TW{1'b0}};
                    if (bit_cnt_r == 3'd7) begin
                        rx_data_nxt_s  = {rx_shift_r, sd_sync_r};
                        rx_valid_nxt_s = 1'b1;
                        busy_nxt_s     = 1'b0;
                        state_nxt_s    = IDLE;
                    end else begin
                        state_nxt_s = SHIFT;
                    end
                end else if (fall_s) begin
                    sd_out_nxt_s   = tx_shift_r[7];
                    tx_shift_nxt_s = {tx_shift_r[6:0], 1'b0};
                    idle_cnt_nxt_s = {TW{1'b0}};
                end else if (timeout_hit_s) begin
                    // Partial byte is abandoned; the popped response byte is not replayed.
                    timeout_nxt_s  = 1'b1;
                    sd_out_nxt_s   = 1'b1;
                    busy_nxt_s     = 1'b0;
                    idle_cnt_nxt_s = {TW{1'b0}};
                    state_nxt_s    = IDLE;
                end else begin
                    idle_cnt_nxt_s = idle_cnt_r + 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Transfer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            tx_shift_r  <= 8'h00;
            rx_shift_r  <= 7'h00;
            bit_cnt_r   <= 3'd0;
            idle_cnt_r  <= {TW{1'b0}};
            sd_out_r    <= 1'b1;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            busy_r      <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            tx_shift_r  <= tx_shift_nxt_s;
            rx_shift_r  <= rx_shift_nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            idle_cnt_r  <= idle_cnt_nxt_s;
            sd_out_r    <= sd_out_nxt_s;
            rx_data_r   <= rx_data_nxt_s;
            rx_valid_r  <= rx_valid_nxt_s;
            busy_r      <= busy_nxt_s;
            timeout_r   <= timeout_nxt_s;
        end
    end

    assign sd_out      = sd_out_r;
    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_r;
    assign tx_ready    = ~fifo_full_s;

endmodule

// File: tb/tb_link_peer.sv
// Self-checking bench for link_peer: directed and random byte exchanges against a queue model.
`timescale 1ns/1ps
module tb_link_peer;
    import link_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 16384;
    localparam int HALF  = 64;
    localparam int MHALF = 256;

    logic       clk = 1'b0;
    logic       reset, sck_in, sd_in, tx_valid;
    logic [7:0] tx_data;
    logic       sd_out, sck_out, sck_oe, tx_ready, rx_valid, busy, timeout_err;
    logic [7:0] rx_data;
`ifdef LINK_PEER_CLK_MASTER_EN
    logic       start;
`endif

    int checks = 0;
    int errors = 0;
    int rxv_cnt = 0;
    int to_cnt = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    link_peer #(
        .FIFO_DEPTH(DEPTH), .IDLE_BYTE(8'hFF), .TIMEOUT_CYCLES(TMO), .SCK_HALF_PERIOD(MHALF)
    ) dut (
        .clk(clk), .reset(reset), .sck_in(sck_in), .sd_in(sd_in),
`ifdef LINK_PEER_CLK_MASTER_EN
        .start(start),
`endif
        .sd_out(sd_out), .sck_out(sck_out), .sck_oe(sck_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .timeout_err(timeout_err)
    );

    // Pulse counters, sampled just after each active edge.
    always @(posedge clk) begin
        #1;
        if (rx_valid === 1'b1) rxv_cnt++;
        if (timeout_err === 1'b1) to_cnt++;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkint(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        chk1("tx_ready", tx_ready, q.size() < DEPTH);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        if (q.size() < DEPTH) q.push_back(b);
    endtask

    // Drive nbits SCK periods with rxb on SOUT; expect the model's next response on SIN.
    task automatic xfer(input logic [7:0] rxb, input int nbits);
        logic [7:0] exp_tx;
        int rxv0;
        rxv0 = rxv_cnt;
        if (q.size() > 0) exp_tx = q.pop_front();
        else exp_tx = 8'hFF;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            sck_in = 1'b0;
            sd_in  = rxb[7-i];
            repeat (3) @(negedge clk);
            chk1($sformatf("sd_out bit%0d of %h", i, exp_tx), sd_out, exp_tx[7-i]);
            if (i == 0) chk1("busy at start", busy, 1'b1);
            repeat (HALF - 3) @(negedge clk);
            sck_in = 1'b1;
            if (i == 7) begin
                repeat (2) @(negedge clk);
                chk1("rx_valid early", rx_valid, 1'b0);
                @(negedge clk);
                chk1("rx_valid at 3", rx_valid, 1'b1);
                chk8("rx_data", rx_data, rxb);
                @(negedge clk);
                chk1("rx_valid width", rx_valid, 1'b0);
                chk1("busy after byte", busy, 1'b0);
                repeat (HALF - 5) @(negedge clk);
            end else begin
                repeat (HALF - 1) @(negedge clk);
            end
        end
        if (nbits == 8) chkint("rx_valid pulses", rxv_cnt - rxv0, 1);
    endtask

    initial begin
        int to0, rxv0, n;
        reset = 1'b1; sck_in = 1'b1; sd_in = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
`ifdef LINK_PEER_CLK_MASTER_EN
        start = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk1("rst sd_out", sd_out, 1'b1);
        chk1("rst sck_out", sck_out, 1'b1);
        chk1("rst sck_oe", sck_oe, 1'b0);
        chk8("rst rx_data", rx_data, 8'h00);
        chk1("rst rx_valid", rx_valid, 1'b0);
        chk1("rst busy", busy, 1'b0);
        chk1("rst timeout_err", timeout_err, 1'b0);
        chk1("rst tx_ready", tx_ready, 1'b1);
        reset = 1'b0;
        repeat (5) @(negedge clk);

`ifndef LINK_PEER_CLK_MASTER_EN
        // Byte exchange, then empty-queue transfer.
        push(8'hA5);
        xfer(8'h3C, 8);
        xfer(8'h81, 8);

        // Queue full: the fifth push is dropped.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
        for (int k = 0; k < 5; k++) xfer(8'($urandom), 8);

        // Timeout on a partial byte, then a clean byte.
        to0 = to_cnt; rxv0 = rxv_cnt;
        xfer(8'hB7, 3);
        repeat (TMO - 2 * HALF) @(negedge clk);
        chkint("timeout not early", to_cnt - to0, 0);
        repeat (2 * HALF + 20) @(negedge clk);
        chkint("timeout pulses", to_cnt - to0, 1);
        chkint("no rx_valid on abort", rxv_cnt - rxv0, 0);
        chk1("busy after timeout", busy, 1'b0);
        chk1("sd_out after timeout", sd_out, 1'b1);
        xfer(8'hC3, 8);

        // Random pushes and exchanges.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(0, 5);
            for (int k = 0; k < n; k++) push(8'($urandom));
            xfer(8'($urandom), 8);
        end

        // Reset mid-byte flushes the queue.
        q.delete();
        reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
        push(8'h77); push(8'h66);
        xfer(8'hAA, 4);
        chk1("busy mid-byte", busy, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk1("mid rst sd_out", sd_out, 1'b1);
        chk1("mid rst busy", busy, 1'b0);
        chk8("mid rst rx_data", rx_data, 8'h00);
        chk1("mid rst rx_valid", rx_valid, 1'b0);
        chk1("mid rst timeout_err", timeout_err, 1'b0);
        chk1("mid rst tx_ready", tx_ready, 1'b1);
        chk1("mid rst sck_oe", sck_oe, 1'b0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        xfer(8'h5C, 8);
`else
        // Peer-driven clock: 16 edges MHALF apart, byte 5A out, F0 in.
        begin
            logic [7:0] exp_tx;
            logic [7:0] gb_byte;
            logic prev;
            int gap, k;
            gb_byte = 8'hF0;
            push(8'h5A);
            exp_tx = q.pop_front();
            prev = sck_out;
            k = 0;
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            for (int e = 0; e < 16; e++) begin
                gap = 0;
                while (sck_out === prev && gap < 4 * MHALF) begin
                    @(negedge clk);
                    gap++;
                end
                chk1($sformatf("sck_out edge%0d seen", e), sck_out, ~prev);
                prev = sck_out;
                if (e > 0) chkint($sformatf("edge%0d spacing", e), gap, MHALF);
                if (sck_out === 1'b0 && k < 8) begin
                    sd_in = gb_byte[7-k];
                    chk1($sformatf("master sd_out bit%0d", k), sd_out, exp_tx[7-k]);
                    k++;
                end
            end
            chk1("sck_oe after last rise", sck_oe, 1'b0);
            repeat (4) @(negedge clk);
            chk8("master rx_data", rx_data, gb_byte);
            chk1("master sck_out high", sck_out, 1'b1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
